// File: rtl/parity_tx_pkg.sv
// Shared types and frame constants for the parity serial transmitter.
package parity_tx_pkg;

  localparam int unsigned FRAME_BITS = 7;  // start + 4 data + parity + stop
  localparam int unsigned DATA_BITS  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/parity_calc.sv
// Even-parity generator: output makes the total count of ones even.
module parity_calc
  import parity_tx_pkg::*;
(
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter: start, 4 data bits LSB first, even parity, stop.
module parity_frame_tx
  import parity_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   parity;
  logic                   wrap;

  // Parity is taken from the latched nibble, so it cannot follow in_data.
  parity_calc u_parity (
    .data_i   (data_q),
    .parity_o (parity)
  );

  assign wrap       = (clk_cnt_q == CNT_LAST);
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_out     = tx_q;
  assign frame_done = done_q;

  // Next-state, counters and latched data.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d   = START;
        data_d    = in_data;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else begin
      clk_cnt_d = wrap ? '0 : clk_cnt_q + CW'(1);
      case (state_q)
        START:  if (wrap) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
                end
        DATA:   if (wrap) begin
                  if (bit_cnt_q == BIT_LAST) state_d = PARITY;
                  else bit_cnt_d = bit_cnt_q + BW'(1);
                end
        PARITY: if (wrap) state_d = STOP;
        STOP:   if (wrap) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so the line changes on the
  // same edge as the state that owns it (start bit right after accept).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = parity;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (clk_cnt_d == CNT_LAST);
  end

  // State registers; reset wins over any accept on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx at CLKS_PER_BIT 4 and 1.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [3:0] din;
  int         sel;  // 0: CLKS_PER_BIT=4 instance, 1: CLKS_PER_BIT=1 instance

  logic rdy4, tx4, busy4, done4;
  logic rdy1, tx1, busy1, done1;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (din),
    .in_valid   (vld && (sel == 0)),
    .in_ready   (rdy4),
    .tx_out     (tx4),
    .busy       (busy4),
    .frame_done (done4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (din),
    .in_valid   (vld && (sel == 1)),
    .in_ready   (rdy1),
    .tx_out     (tx1),
    .busy       (busy1),
    .frame_done (done1)
  );

  // Reference frame: start, d0..d3, parity chosen so the ones count is even, stop.
  function automatic logic exp_bit(input logic [3:0] n, input int idx);
    case (idx)
      0:       return 1'b0;
      1, 2, 3, 4: return n[idx-1];
      5:       return logic'($countones(n) % 2);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic tx, input logic bz,
                            input logic rd, input logic dn);
    chk({tag, "_tx"},    sel ? tx1   : tx4,   tx);
    chk({tag, "_busy"},  sel ? busy1 : busy4, bz);
    chk({tag, "_ready"}, sel ? rdy1  : rdy4,  rd);
    chk({tag, "_done"},  sel ? done1 : done4, dn);
  endtask

  // mode 0: drop in_valid after accept; 1: random noise on inputs while busy;
  // 2: keep in_valid high (back-to-back).
  task automatic run_frame(input string tag, input logic [3:0] n, input int mode);
    int cpb;
    cpb = sel ? 1 : 4;
    check_outs({tag, "_pre"}, 1'b1, 1'b0, 1'b1, 1'b0);
    din = n;
    vld = 1'b1;
    tick();
    for (int k = 0; k < 7 * cpb; k++) begin
      check_outs(tag, exp_bit(n, k / cpb), 1'b1, 1'b0, (k == 7 * cpb - 1));
      if (mode == 0) vld = 1'b0;
      else if (mode == 1) begin
        vld = 1'($urandom_range(0, 1));
        din = 4'($urandom);
      end
      if (k == 7 * cpb - 1 && mode != 2) vld = 1'b0;
      tick();
    end
    check_outs({tag, "_post"}, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] r;
    int m;
    sel = 0;
    rst = 1'b1;
    vld = 1'b0;
    din = 4'h0;
    tick();
    tick();
    check_outs("reset4", 1'b1, 1'b0, 1'b1, 1'b0);
    sel = 1;
    check_outs("reset1", 1'b1, 1'b0, 1'b1, 1'b0);
    sel = 0;
    rst = 1'b0;
    tick();

    // Directed frames at 4 clocks per bit.
    run_frame("f1011", 4'b1011, 0);
    run_frame("f0000", 4'b0000, 0);
    run_frame("f1111", 4'b1111, 0);

    // Back-to-back with in_valid held: exactly one IDLE cycle between frames.
    run_frame("b2b_3", 4'h3, 2);
    run_frame("b2b_5", 4'h5, 0);

    // Input changes while busy must not disturb the frame.
    run_frame("noise_a", 4'hA, 1);
    run_frame("noise_6", 4'h6, 1);

    // Reset in the middle of d2 aborts the frame with no stop or done.
    din = 4'b1101;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int k = 0; k < 3 * 4 + 1; k++) begin
      check_outs("abort_pre", exp_bit(4'b1101, k / 4), 1'b1, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("abort_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7 * 4 + 2; k++) begin
      tick();
      check_outs("abort_after", 1'b1, 1'b0, 1'b1, 1'b0);
    end

    // Reset beats a simultaneous accept.
    rst = 1'b1;
    vld = 1'b1;
    din = 4'h9;
    tick();
    rst = 1'b0;
    vld = 1'b0;
    check_outs("rst_prio", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("rst_prio2", 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized frames on both instances.
    for (int i = 0; i < 6; i++) begin
      sel = i % 2;
      r = 4'($urandom);
      m = int'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", i), r, m);
    end

    // One bit per clock.
    sel = 1;
    run_frame("cpb1_0110", 4'b0110, 0);
    run_frame("cpb1_b2b", 4'h3, 2);
    run_frame("cpb1_b2b2", 4'hC, 0);
    sel = 0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  4  nibble to transmit; d0 is the LSB.
REQ-005 in_valid  input  1  upstream asserts when in_data is valid.
REQ-006 in_ready  output  1  block can accept a nibble this cycle.
REQ-007 tx_out  output  1  serial line; idle high; registered.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 in_ready SHALL equal (state == IDLE); busy SHALL equal (state != IDLE).
REQ-012 Accept SHALL occur on a rising edge where in_valid && in_ready; in_data is then latched and state goes to START.
REQ-013 Parity SHALL be computed from the latched nibble as d0^d1^d2^d3, giving an even count of ones across the 4 data bits plus the parity bit.
REQ-014 Frame order SHALL be: start(0), d0, d1, d2, d3, parity, stop(1); 7 bits in total, LSB first.
REQ-015 Each bit SHALL drive tx_out for exactly CLKS_PER_BIT cycles; the whole frame SHALL span 7*CLKS_PER_BIT cycles.
REQ-016 Latency: tx_out SHALL go 0 in the first cycle after the accepting edge.
REQ-017 Clock counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; width is max(1,$clog2(CLKS_PER_BIT)).
REQ-018 Bit counter SHALL count 0..3 in DATA only; DATA exits to PARITY when it reaches 3 and the clock counter wraps.
REQ-019 frame_done SHALL be high only in the final STOP cycle; state returns to IDLE on the next edge.
REQ-020 Back-to-back: in_ready is high the cycle after frame_done, so a held in_valid starts the next start bit with no extra idle cycle beyond that IDLE cycle.
REQ-021 in_valid and in_data changes while busy SHALL be ignored; the latched nibble is stable for the whole frame.
REQ-022 CLKS_PER_BIT=1 SHALL produce one bit per cycle with identical ordering.
REQ-023 In IDLE, tx_out SHALL be 1.

Reset
REQ-024 On rst: state=IDLE, counters=0, latched data=0, tx_out=1, busy=0, in_ready=1 (after the reset edge), frame_done=0.
REQ-025 rst asserted mid-frame SHALL abort the frame at the next edge, with no stop bit or frame_done emitted.
REQ-026 rst SHALL take priority over a simultaneous in_valid accept.

Structure
REQ-027 Package parity_tx_pkg SHALL hold the state enum typedef tx_state_t and constants FRAME_BITS=7 and DATA_BITS=4.
REQ-028 One combinational sub-module parity_calc (4-bit in, 1-bit even parity out) SHALL be instantiated on the latched nibble.
REQ-029 Target size is 120-400 RTL lines; no latches; all outputs registered except in_ready and busy, which decode the state.

Verification
REQ-030 CLKS_PER_BIT=4, in_data=4'b1011 -> tx_out 0,1,1,0,1,1,1 per 4-cycle bit (parity 1); frame_done at cycle 28 after accept.
REQ-031 in_data=4'b0000 -> bits 0,0,0,0,0,0(parity),1; in_data=4'b1111 -> parity 0.
REQ-032 in_valid held high with 4'h3 then 4'h5 -> two contiguous frames separated by exactly one IDLE cycle; second parity 0.
REQ-033 rst pulsed during DATA bit d2 -> tx_out=1, busy=0, in_ready=1 after the edge; no frame_done.
REQ-034 in_valid toggled with new data while busy -> transmitted bits match the originally latched nibble only.
REQ-035 CLKS_PER_BIT=1, in_data=4'b0110 -> 7-cycle frame 0,0,1,1,0,0,1; frame_done on cycle 7.
